// File: rtl/ad9361_spi_pkg.sv
// Shared constants and FSM state type for the AD9361 SPI responder.
package ad9361_spi_pkg;
   localparam int RW_BIT     = 15;
   localparam int NB_MSB     = 14;
   localparam int NB_LSB     = 12;
   localparam int ADDR_MSB   = 9;
   localparam int INSTR_BITS = 16;
   localparam int BYTE_BITS  = 8;
   localparam logic [9:0] CHIPID_ADDR = 10'h037;

   typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;
endpackage

// File: rtl/ad9361_spi_regfile.sv
// 2**ADDR_W x 8 register file: SPI write/read port plus host read port, registered reads.
// With AD9361_SPI_SLAVE_CHIPID_EN, address 0x037 reads back PRODUCT_ID on both ports.
module ad9361_spi_regfile
   import ad9361_spi_pkg::*;
#(
   parameter int         ADDR_W     = 10,
   parameter logic [7:0] PRODUCT_ID = 8'h0A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   input  logic [ADDR_W-1:0] host_addr,
   output logic [7:0]        host_rdata
);
`ifdef AD9361_SPI_SLAVE_CHIPID_EN
   localparam bit CHIPID_EN = 1'b1;
`else
   localparam bit CHIPID_EN = 1'b0;
`endif

   logic [7:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Reads see the pre-write contents when both ports hit the same address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata      <= '0;
         host_rdata <= '0;
      end else begin
         rdata      <= (CHIPID_EN && addr == ADDR_W'(CHIPID_ADDR)) ? PRODUCT_ID : mem[addr];
         host_rdata <= (CHIPID_EN && host_addr == ADDR_W'(CHIPID_ADDR)) ? PRODUCT_ID : mem[host_addr];
      end
   end
endmodule

// File: rtl/ad9361_spi_slave.sv
// AD9361-style 4-wire SPI responder (mode 1, MSB first) backed by a 1024x8 register file.
// Optional macro AD9361_SPI_SLAVE_CHIPID_EN: 0x037 is a read-only product ID.
//  state | meaning
//  IDLE  | csn high, waiting for csn falling edge
//  INSTR | shifting in the 16-bit instruction
//  DATA  | transferring data bytes (read or write)
//  DONE  | all bytes transferred, clocks ignored until csn rises
module ad9361_spi_slave
   import ad9361_spi_pkg::*;
#(
   parameter int         ADDR_W      = 10,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] PRODUCT_ID  = 8'h0A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_csn,
   input  logic              spi_clk,
   input  logic              spi_sdi,
   output logic              spi_sdo,
   output logic              spi_sdo_oe,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] host_addr,
   output logic [7:0]        host_rdata,
   output logic              busy,
   output logic              err_abort
);
`ifdef AD9361_SPI_SLAVE_CHIPID_EN
   localparam bit CHIPID_EN = 1'b1;
`else
   localparam bit CHIPID_EN = 1'b0;
`endif
   localparam logic [3:0] INSTR_LAST = 4'(INSTR_BITS - 1);
   localparam logic [2:0] BYTE_LAST  = 3'(BYTE_BITS - 1);

   logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, sdi_sync;
   logic csn_d, sclk_d;
   logic csn_s, sclk_s, sdi_s;
   logic csn_fall, csn_rise, sclk_fall, sclk_rise;

   state_t state_q, state_d;
   logic [3:0]        bit_cnt_q;
   logic [14:0]       rx_q;
   logic [7:0]        tx_q;
   logic              rw_q, sdo_q;
   logic [2:0]        bytes_left_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        ld_q;
   logic              instr_done, byte_done, err_d, mem_we;
   logic [7:0]        mem_wdata, spi_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csn_sync  <= '1;
         sclk_sync <= '0;
         sdi_sync  <= '0;
         csn_d     <= 1'b1;
         sclk_d    <= 1'b0;
      end else begin
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
         csn_d     <= csn_s;
         sclk_d    <= sclk_s;
      end
   end

   assign csn_s     = csn_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign csn_fall  = csn_d & ~csn_s;
   assign csn_rise  = ~csn_d & csn_s;
   assign sclk_fall = sclk_d & ~sclk_s;
   assign sclk_rise = ~sclk_d & sclk_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      instr_done = 1'b0;
      byte_done  = 1'b0;
      err_d      = 1'b0;
      if (csn_rise) begin
         state_d = IDLE;
         err_d   = (state_q == INSTR) || (state_q == DATA && bit_cnt_q != '0);
      end else begin
         case (state_q)
            IDLE:  if (csn_fall) state_d = INSTR;
            INSTR: if (sclk_fall && bit_cnt_q == INSTR_LAST) begin
                      instr_done = 1'b1;
                      state_d    = DATA;
                   end
            DATA:  if (sclk_fall && bit_cnt_q[2:0] == BYTE_LAST) begin
                      byte_done = 1'b1;
                      if (bytes_left_q == '0) state_d = DONE;
                   end
            default: ;
         endcase
      end
   end

   assign mem_wdata  = {rx_q[6:0], sdi_s};
   assign mem_we     = byte_done && rw_q && !(CHIPID_EN && addr_q == ADDR_W'(CHIPID_ADDR));
   assign spi_sdo_oe = (state_q == DATA) && !rw_q;
   assign spi_sdo    = sdo_q & spi_sdo_oe;
   assign busy       = ((state_q != IDLE) || csn_fall) && !csn_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q    <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         rw_q         <= 1'b0;
         sdo_q        <= 1'b0;
         bytes_left_q <= '0;
         addr_q       <= '0;
         ld_q         <= '0;
         wr_valid     <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         err_abort    <= 1'b0;
      end else begin
         err_abort <= err_d;
         wr_valid  <= mem_we;
         if (mem_we) begin
            wr_addr <= addr_q;
            wr_data <= mem_wdata;
         end
         if (state_q == IDLE && csn_fall) bit_cnt_q <= '0;
         if ((state_q == INSTR || state_q == DATA) && sclk_fall && !csn_rise) begin
            rx_q      <= {rx_q[13:0], sdi_s};
            bit_cnt_q <= (instr_done || byte_done) ? 4'd0 : bit_cnt_q + 4'd1;
         end
         if (instr_done) begin
            rw_q         <= rx_q[RW_BIT-1];
            bytes_left_q <= rx_q[NB_MSB-1:NB_LSB-1];
            addr_q       <= ADDR_W'({rx_q[ADDR_MSB-1:0], sdi_s});
         end
         if (byte_done) begin
            addr_q       <= addr_q - 1'b1;
            bytes_left_q <= bytes_left_q - 3'd1;
         end
         // Read data appears two cycles after the address settles (addr reg + registered RAM).
         ld_q <= {ld_q[0], (instr_done && !rx_q[RW_BIT-1]) ||
                           (byte_done && !rw_q && bytes_left_q != '0)};
         if (ld_q[1]) begin
            tx_q <= spi_rdata;
         end else if (spi_sdo_oe && sclk_rise) begin
            sdo_q <= tx_q[7];
            tx_q  <= {tx_q[6:0], 1'b0};
         end
         if (state_q != DATA) sdo_q <= 1'b0;
      end
   end

   ad9361_spi_regfile #(
      .ADDR_W     (ADDR_W),
      .PRODUCT_ID (PRODUCT_ID)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .we         (mem_we),
      .addr       (addr_q),
      .wdata      (mem_wdata),
      .rdata      (spi_rdata),
      .host_addr  (host_addr),
      .host_rdata (host_rdata)
   );
endmodule

// File: tb/tb_ad9361_spi_slave.sv
// Scoreboard bench for ad9361_spi_slave: directed SPI transactions, monitors pop expected writes/reads/aborts.
module tb_ad9361_spi_slave;
   localparam int HALF = 6;

   logic       clk = 1'b0, rst = 1'b1;
   logic       spi_csn = 1'b1, spi_clk = 1'b0, spi_sdi = 1'b0;
   logic [9:0] host_addr = '0;
   logic       spi_sdo, spi_sdo_oe, wr_valid, busy, err_abort;
   logic [9:0] wr_addr;
   logic [7:0] wr_data, host_rdata;

   ad9361_spi_slave dut (
      .clk(clk), .rst(rst), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_sdi(spi_sdi),
      .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .host_addr(host_addr), .host_rdata(host_rdata), .busy(busy),
      .err_abort(err_abort)
   );

   always #10 clk = ~clk;

   typedef struct { logic [9:0] a; logic [7:0] d; } wr_t;
   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   int         exp_err = 0;
   int         checks = 0, errors = 0;
   int         oe_edges = 0, rd_n = 0;
   logic [7:0] rd_sh = '0;
   wr_t        wr_e;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wr_valid === 1'b1) begin
         if (exp_wr.size() == 0) begin
            chk("wr_unexpected_addr_data", {14'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
         end else begin
            wr_e = exp_wr.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(wr_e.a));
            chk("wr_data", 32'(wr_data), 32'(wr_e.d));
         end
      end
   end

   always @(negedge clk) begin
      if (err_abort === 1'b1) begin
         chk("err_abort_expected", 32'(exp_err > 0), 1);
         if (exp_err > 0) exp_err--;
      end
   end

   always @(negedge spi_clk) begin
      if (spi_sdo_oe === 1'b1) begin
         rd_sh = {rd_sh[6:0], spi_sdo};
         rd_n++;
         oe_edges++;
         if (rd_n == 8) begin
            rd_n = 0;
            if (exp_rd.size() == 0) chk("rd_unexpected", 32'(rd_sh), 32'hFFFF_FFFF);
            else                    chk("rd_byte", 32'(rd_sh), 32'(exp_rd.pop_front()));
         end
      end
   end

   // Mode-1 master: sdi changes on rising spi_clk, slave samples on falling. rst_at>=0 pulses rst before that bit.
   task automatic send(input logic [15:0] instr, input logic [63:0] data, input int nbits, input int rst_at);
      logic [79:0] bits;
      bits = {instr, data};
      @(negedge clk);
      spi_csn = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            chk("rst_outputs", 32'({busy, wr_valid, err_abort, spi_sdo_oe, spi_sdo}), 0);
            spi_csn = 1'b1;
            spi_sdi = 1'b0;
            repeat (4) @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            return;
         end
         spi_clk = 1'b1;
         spi_sdi = bits[79-i];
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      chk("busy_active", 32'(busy), 1);
      spi_csn = 1'b1;
      spi_sdi = 1'b0;
      repeat (6) @(negedge clk);
      chk("busy_idle", 32'(busy), 0);
   endtask

   task automatic host_chk(input string name, input logic [9:0] a, input logic [7:0] exp);
      host_addr = a;
      @(negedge clk);
      chk(name, 32'(host_rdata), 32'(exp));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int oe0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({spi_sdo, spi_sdo_oe, wr_valid, busy, err_abort}), 0);
      chk("reset_host_rdata", 32'(host_rdata), 0);
      chk("reset_wr_addr_data", 32'({wr_addr, wr_data}), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // single write; trailing byte lands in DONE and must be ignored
      exp_wr.push_back('{10'h015, 8'h5A});
      send(16'h8015, {8'h5A, 8'h33, 48'h0}, 32, -1);
      host_chk("host_015", 10'h015, 8'h5A);

      exp_wr.push_back('{10'h002, 8'hAA});
      exp_wr.push_back('{10'h001, 8'hBB});
      exp_wr.push_back('{10'h000, 8'hCC});
      send(16'hA002, {24'hAABBCC, 40'h0}, 40, -1);
      host_chk("host_001", 10'h001, 8'hBB);

      exp_wr.push_back('{10'h000, 8'h11});
      exp_wr.push_back('{10'h3FF, 8'h22});
      send(16'h9000, {16'h1122, 48'h0}, 32, -1);
      host_chk("host_3ff", 10'h3FF, 8'h22);
      host_chk("host_000", 10'h000, 8'h11);

      // 2-byte read with wrap, plus a trailing byte while in DONE
      oe0 = oe_edges;
      exp_rd.push_back(8'h11);
      exp_rd.push_back(8'h22);
      send(16'h1000, 64'h0, 40, -1);
      chk("read_oe_edges", 32'(oe_edges - oe0), 16);
      chk("idle_sdo_oe", 32'({spi_sdo, spi_sdo_oe}), 0);

      exp_wr.push_back('{10'h020, 8'h3C});
      send(16'h8020, {8'h3C, 56'h0}, 24, -1);
      exp_err++;
      send(16'h8020, {8'h99, 56'h0}, 11, -1);
      exp_err++;
      send(16'h8020, {8'h99, 56'h0}, 21, -1);
      host_chk("host_020_after_abort", 10'h020, 8'h3C);

      // reset during byte 2 of a 3-byte write
      exp_wr.push_back('{10'h030, 8'h44});
      send(16'hA030, {24'h445566, 40'h0}, 40, 28);
      host_chk("host_030_after_rst", 10'h030, 8'h44);
      exp_wr.push_back('{10'h010, 8'h77});
      send(16'h8010, {8'h77, 56'h0}, 24, -1);
      host_chk("host_010", 10'h010, 8'h77);

`ifdef AD9361_SPI_SLAVE_CHIPID_EN
      send(16'h8037, {8'hFF, 56'h0}, 24, -1);
      exp_rd.push_back(8'h0A);
      send(16'h0037, 64'h0, 24, -1);
      host_chk("host_037", 10'h037, 8'h0A);
`else
      exp_wr.push_back('{10'h037, 8'hFF});
      send(16'h8037, {8'hFF, 56'h0}, 24, -1);
      exp_rd.push_back(8'hFF);
      send(16'h0037, 64'h0, 24, -1);
      host_chk("host_037", 10'h037, 8'hFF);
`endif

      repeat (10) @(negedge clk);
      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("rd_queue_empty", exp_rd.size(), 0);
      chk("err_pending", 32'(exp_err), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
